// File: rtl/vid_capture.sv
// Game-video capture front end: recovers line/frame structure from blanking alone
// and emits frame-store write strobes with (col,row) addresses and RGB444 data.
module vid_capture #(
    parameter int H_ACTIVE   = 336,
    parameter int V_ACTIVE   = 240,
    parameter int VBLANK_MIN = 512
) (
    input  logic        MCKF,
    input  logic        reset,
    input  logic [15:0] VIDOUT,
    input  logic        VIDBLANK_b,
    output logic        wr_en,
    output logic [8:0]  wr_col,
    output logic [7:0]  wr_row,
    output logic [11:0] wr_data,
    output logic        frame_start,
    output logic        line_done,
    output logic        locked,
    output logic        err_overrun
);

    localparam int BW = $clog2(VBLANK_MIN + 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'(VBLANK_MIN);
    localparam logic [BW-1:0] BLANK_HIT = BW'(VBLANK_MIN - 1);
    localparam logic [8:0]    H_LIM     = 9'(H_ACTIVE);
    localparam logic [7:0]    V_LIM     = 8'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, ARMED, ACTIVE} state_t;

    state_t        state;
    logic [BW-1:0] blank_run;
    logic [8:0]    col;
    logic [7:0]    row;
    logic          bad;
    logic          prev_act;
    logic          vb_hit;

    // The cycle on which blank_run steps onto VBLANK_MIN marks vertical blank.
    assign vb_hit = !VIDBLANK_b && (blank_run == BLANK_HIT);

    always_ff @(posedge MCKF or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            blank_run   <= '0;
            col         <= '0;
            row         <= '0;
            bad         <= 1'b0;
            prev_act    <= 1'b0;
            wr_en       <= 1'b0;
            wr_col      <= '0;
            wr_row      <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            locked      <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            prev_act    <= VIDBLANK_b;

            if (VIDBLANK_b)
                blank_run <= '0;
            else if (blank_run != BLANK_MAX)
                blank_run <= blank_run + 1'b1;

            case (state)
                SEARCH: begin
                    if (vb_hit)
                        state <= ARMED;
                end

                ARMED: begin
                    if (VIDBLANK_b) begin
                        wr_en       <= 1'b1;
                        wr_col      <= '0;
                        wr_row      <= '0;
                        wr_data     <= VIDOUT[11:0];
                        frame_start <= 1'b1;
                        col         <= 9'd1;
                        row         <= '0;
                        bad         <= 1'b0;
                        state       <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (VIDBLANK_b) begin
                        if (col < H_LIM && row < V_LIM) begin
                            wr_en   <= 1'b1;
                            wr_col  <= col;
                            wr_row  <= row;
                            wr_data <= VIDOUT[11:0];
                            col     <= col + 1'b1;
                        end else begin
                            err_overrun <= 1'b1;
                            bad         <= 1'b1;
                        end
                    end else begin
                        // Line end and frame end never share a cycle since VBLANK_MIN > 1.
                        if (prev_act) begin
                            line_done <= 1'b1;
                            col       <= '0;
                            if (row != 8'hFF)
                                row <= row + 1'b1;
                        end
                        if (vb_hit) begin
                            locked <= (row == V_LIM) && !bad;
                            state  <= ARMED;
                        end
                    end
                end

                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_capture.sv
// Directed bench for vid_capture using a reduced frame geometry (8x6, 16-cycle vblank threshold).
module tb_vid_capture;

    localparam int H   = 8;
    localparam int V   = 6;
    localparam int VBM = 16;
    localparam int HB  = 4;
    localparam int VBL = 20;

    logic        MCKF = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] VIDOUT = 16'h0;
    logic        VIDBLANK_b = 1'b0;
    logic        wr_en;
    logic [8:0]  wr_col;
    logic [7:0]  wr_row;
    logic [11:0] wr_data;
    logic        frame_start;
    logic        line_done;
    logic        locked;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;

    int n_wr = 0, n_fs = 0, n_ld = 0, n_bad_data = 0, n_bad_fs = 0, n_oob = 0;

    vid_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VBM)) dut (
        .MCKF(MCKF), .reset(reset), .VIDOUT(VIDOUT), .VIDBLANK_b(VIDBLANK_b),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .frame_start(frame_start), .line_done(line_done), .locked(locked),
        .err_overrun(err_overrun)
    );

    always #5 MCKF = ~MCKF;

    // Tallies output events; expected data follows the stimulus pattern {A, col[3:0], row}.
    always @(negedge MCKF) begin
        if (wr_en) begin
            n_wr++;
            if (wr_data !== {wr_col[3:0], wr_row}) n_bad_data++;
            if (int'(wr_col) >= H || int'(wr_row) >= V) n_oob++;
            if (wr_col == 9'd0 && wr_row == 8'd0 && !frame_start) n_bad_fs++;
        end
        if (frame_start) begin
            n_fs++;
            if (!(wr_en && wr_col == 9'd0 && wr_row == 8'd0)) n_bad_fs++;
        end
        if (line_done) n_ld++;
    end

    function automatic logic [15:0] pix(input int c, input int r);
        return {4'hA, 4'(c), 8'(r)};
    endfunction

    task automatic cyc(input logic b, input logic [15:0] p);
        @(posedge MCKF);
        #1;
        VIDBLANK_b = b;
        VIDOUT     = p;
    endtask

    task automatic send_line(input int r, input int n, input int c0);
        for (int c = c0; c < n; c++) cyc(1'b1, pix(c, r));
        for (int i = 0; i < HB; i++) cyc(1'b0, 16'h0);
    endtask

    task automatic send_vblank(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0);
    endtask

    task automatic send_frame(input int nlines, input int long_row, input int long_n);
        for (int r = 0; r < nlines; r++) send_line(r, (r == long_row) ? long_n : H, 0);
        send_vblank(VBL);
    endtask

    task automatic do_reset();
        @(posedge MCKF);
        #2;
        reset = 1'b1;
        VIDBLANK_b = 1'b0;
        VIDOUT = 16'h0;
        repeat (2) @(posedge MCKF);
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({wr_en, frame_start, line_done, locked, err_overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {wr_en, frame_start, line_done, locked, err_overrun});
        end
        checks++;
        if ({wr_col, wr_row, wr_data} !== 29'h0) begin
            errors++;
            $display("FAIL reset_bus: got col=%0d row=%0d data=%h want 0", wr_col, wr_row, wr_data);
        end
        repeat (2) @(posedge MCKF);
        #3;
        reset = 1'b0;
    endtask

    task automatic test_clean_frames();
        int w0, f0, l0, d0, b0, o0;
        send_vblank(VBL);
        w0 = n_wr; f0 = n_fs; l0 = n_ld; d0 = n_bad_data; b0 = n_bad_fs; o0 = n_oob;
        send_frame(V, -1, H);
        checks++;
        if (n_wr - w0 !== H * V) begin errors++; $display("FAIL clean_f1_writes: got %0d want %0d", n_wr - w0, H * V); end
        checks++;
        if (n_ld - l0 !== V) begin errors++; $display("FAIL clean_f1_line_done: got %0d want %0d", n_ld - l0, V); end
        checks++;
        if (n_fs - f0 !== 1) begin errors++; $display("FAIL clean_f1_frame_start: got %0d want 1", n_fs - f0); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL clean_f1_locked: got %b want 1", locked); end
        send_frame(V, -1, H);
        checks++;
        if (n_wr - w0 !== 2 * H * V) begin errors++; $display("FAIL clean_f2_writes: got %0d want %0d", n_wr - w0, 2 * H * V); end
        checks++;
        if (n_ld - l0 !== 2 * V) begin errors++; $display("FAIL clean_f2_line_done: got %0d want %0d", n_ld - l0, 2 * V); end
        checks++;
        if (n_bad_data - d0 !== 0) begin errors++; $display("FAIL clean_data: got %0d bad words want 0", n_bad_data - d0); end
        checks++;
        if (n_bad_fs - b0 !== 0 || n_oob - o0 !== 0) begin
            errors++; $display("FAIL clean_fs_align: got %0d/%0d bad want 0/0", n_bad_fs - b0, n_oob - o0);
        end
        checks++;
        if (locked !== 1'b1 || err_overrun !== 1'b0) begin
            errors++; $display("FAIL clean_status: got locked=%b err=%b want 1/0", locked, err_overrun);
        end
    endtask

    task automatic test_midframe();
        int w0, f0;
        @(posedge MCKF);
        #2;
        reset = 1'b1;
        VIDBLANK_b = 1'b1;
        VIDOUT = pix(40, 3);
        #5;
        reset = 1'b0;
        w0 = n_wr;
        send_line(3, H, 4);
        send_line(4, H, 0);
        send_line(5, H, 0);
        checks++;
        if (n_wr - w0 !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d want 0", n_wr - w0); end
        send_vblank(VBL);
        f0 = n_fs;
        cyc(1'b1, pix(0, 0));
        cyc(1'b1, pix(1, 0));
        #2;
        checks++;
        if ({wr_en, frame_start, wr_col, wr_row} !== {2'b11, 9'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_first_write: got en=%b fs=%b col=%0d row=%0d want 1 1 0 0",
                     wr_en, frame_start, wr_col, wr_row);
        end
        send_line(0, H, 2);
        for (int r = 1; r < V; r++) send_line(r, H, 0);
        send_vblank(VBL);
        checks++;
        if (n_wr - w0 !== H * V || n_fs - f0 !== 1) begin
            errors++; $display("FAIL mid_frame: got writes=%0d fs=%0d want %0d 1", n_wr - w0, n_fs - f0, H * V);
        end
        checks++;
        if (locked !== 1'b1 || err_overrun !== 1'b0) begin
            errors++; $display("FAIL mid_status: got locked=%b err=%b want 1/0", locked, err_overrun);
        end
    endtask

    task automatic test_long_line();
        int w0, l0, o0;
        w0 = n_wr; l0 = n_ld; o0 = n_oob;
        send_frame(V, 5, H + 2);
        checks++;
        if (n_wr - w0 !== H * V || n_oob - o0 !== 0) begin
            errors++; $display("FAIL long_writes: got %0d oob=%0d want %0d 0", n_wr - w0, n_oob - o0, H * V);
        end
        checks++;
        if (err_overrun !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL long_status: got err=%b locked=%b want 1/0", err_overrun, locked);
        end
        checks++;
        if (n_ld - l0 !== V) begin errors++; $display("FAIL long_line_done: got %0d want %0d", n_ld - l0, V); end
        send_frame(V, -1, H);
        checks++;
        if (err_overrun !== 1'b1 || locked !== 1'b1) begin
            errors++; $display("FAIL long_recover: got err=%b locked=%b want 1/1", err_overrun, locked);
        end
    endtask

    task automatic test_extra_line();
        int w0, l0;
        do_reset();
        send_vblank(VBL);
        send_frame(V, -1, H);
        w0 = n_wr; l0 = n_ld;
        send_frame(V + 1, -1, H);
        checks++;
        if (n_wr - w0 !== H * V) begin errors++; $display("FAIL extra_writes: got %0d want %0d", n_wr - w0, H * V); end
        checks++;
        if (n_ld - l0 !== V + 1) begin errors++; $display("FAIL extra_line_done: got %0d want %0d", n_ld - l0, V + 1); end
        checks++;
        if (err_overrun !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL extra_status: got err=%b locked=%b want 1/0", err_overrun, locked);
        end
    endtask

    task automatic test_short_frame();
        int w0;
        do_reset();
        send_vblank(VBL);
        send_frame(V, -1, H);
        w0 = n_wr;
        send_frame(4, -1, H);
        checks++;
        if (n_wr - w0 !== H * 4) begin errors++; $display("FAIL short_writes: got %0d want %0d", n_wr - w0, H * 4); end
        checks++;
        if (locked !== 1'b0 || err_overrun !== 1'b0) begin
            errors++; $display("FAIL short_status: got locked=%b err=%b want 0/0", locked, err_overrun);
        end
        send_frame(V, -1, H);
        checks++;
        if (locked !== 1'b1 || err_overrun !== 1'b0) begin
            errors++; $display("FAIL short_recover: got locked=%b err=%b want 1/0", locked, err_overrun);
        end
    endtask

    task automatic test_async_reset();
        int w0, f0;
        do_reset();
        send_vblank(VBL);
        send_frame(V, -1, H);
        for (int c = 0; c < 5; c++) cyc(1'b1, pix(c, 0));
        #3;
        checks++;
        if (wr_en !== 1'b1 || wr_col !== 9'd3 || locked !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got en=%b col=%0d locked=%b want 1 3 1", wr_en, wr_col, locked);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_en, frame_start, line_done, locked, err_overrun, wr_col, wr_row, wr_data} !== 34'h0) begin
            errors++;
            $display("FAIL areset_clear: got en=%b locked=%b col=%0d row=%0d data=%h want all 0",
                     wr_en, locked, wr_col, wr_row, wr_data);
        end
        @(posedge MCKF);
        #3;
        reset = 1'b0;
        w0 = n_wr;
        send_line(0, H, 5);
        for (int r = 1; r < V; r++) send_line(r, H, 0);
        checks++;
        if (n_wr - w0 !== 0) begin errors++; $display("FAIL areset_no_writes: got %0d want 0", n_wr - w0); end
        send_vblank(VBL);
        f0 = n_fs;
        send_frame(V, -1, H);
        checks++;
        if (n_wr - w0 !== H * V || n_fs - f0 !== 1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL areset_recover: got writes=%0d fs=%0d locked=%b want %0d 1 1",
                     n_wr - w0, n_fs - f0, locked, H * V);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_midframe();
        test_long_line();
        test_extra_line();
        test_short_frame();
        test_async_reset();
        checks++;
        if (n_bad_data !== 0 || n_bad_fs !== 0) begin
            errors++; $display("FAIL global_data: got bad_data=%0d bad_fs=%0d want 0 0", n_bad_data, n_bad_fs);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vid_capture.md
Name: vid_capture

Overview:
- Capture front end on the game-video side of the scan converter, clocked by the game pixel clock MCKF.
- Takes the raw 16-bit pixel stream VIDOUT, qualified by VIDBLANK_b, and recovers the frame and line structure from blanking alone, since no HS/VS is available.
- Produces write strobes with (column, row) addresses and RGB444 data for the 336x240 frame store that the VGA output stage reads.
- Reports frame lock and overrun status.

Parameters:
- H_ACTIVE, 336: maximum active pixels per line accepted.
- V_ACTIVE, 240: maximum active lines per frame accepted.
- VBLANK_MIN, 512: consecutive blanked MCKF cycles that identify vertical blank. Must be > 1 and greater than the longest horizontal blank.

Ports:
- MCKF  input  1  pixel clock. The only clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- VIDOUT  input  16  pixel word. Bits [11:0] are RGB444 (R=[11:8], G=[7:4], B=[3:0]); bits [15:12] are ignored.
- VIDBLANK_b  input  1  active-low blank: 1 = active pixel, 0 = blanked.
- wr_en  output  1  frame-store write strobe, one cycle per accepted pixel.
- wr_col  output  9  write column, 0..H_ACTIVE-1.
- wr_row  output  8  write row, 0..V_ACTIVE-1.
- wr_data  output  12  RGB444 pixel.
- frame_start  output  1  one-cycle pulse coincident with the write of pixel (0,0).
- line_done  output  1  one-cycle pulse on the first blanked cycle after an accepted line.
- locked  output  1  high while the most recently completed frame was well formed.
- err_overrun  output  1  sticky; set when any pixel is discarded for exceeding H_ACTIVE or V_ACTIVE.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - FSM in SEARCH; col, row and blank_run counters 0.
  - Takes effect immediately, including mid-line. After release, nothing is written until a full vertical blank is seen.
- All outputs are registered. The pixel sampled at rising edge k drives wr_* from edge k until edge k+1 (one-cycle latency). wr_data = VIDOUT[11:0].
- blank_run counter:
  - Increments on each cycle with VIDBLANK_b=0 and saturates at VBLANK_MIN.
  - Clears to 0 on any cycle with VIDBLANK_b=1.
- FSM states:
  - SEARCH: active pixels are discarded (wr_en=0, no error). When blank_run reaches VBLANK_MIN, go to ARMED.
  - ARMED: on the first cycle with VIDBLANK_b=1, write the pixel at (0,0), pulse frame_start, then col=1, row=0, go to ACTIVE. This also clears the per-frame bad flag.
  - ACTIVE, active cycle:
    - If col < H_ACTIVE and row < V_ACTIVE: write at (col,row), then col++.
    - Otherwise discard (wr_en=0), set err_overrun and the per-frame bad flag.
  - ACTIVE, 1->0 transition on VIDBLANK_b: pulse line_done, set col=0, row++ (saturating at 255).
  - ACTIVE, blank_run reaches VBLANK_MIN (end of frame): go to ARMED and update locked <= (row == V_ACTIVE) && !bad.
- Short lines (< H_ACTIVE pixels) are accepted and are not errors; unwritten columns keep their previous contents.
- Short frames (< V_ACTIVE lines) clear locked at frame end but do not set err_overrun.
- Excess lines (row == V_ACTIVE) are fully discarded. line_done still pulses for them; row saturates and does not wrap.
- A line end and the vertical-blank threshold can never coincide, because VBLANK_MIN > 1.
- err_overrun is cleared only by reset.
- locked changes only at frame end or on reset.

Test Plan:
- Reset, then 600 blank cycles, then 2 frames of 336x240 (64-cycle hblank, 1000-cycle vblank), pixel = {4'hA, col[3:0], row[7:0]} -> 80640 writes per frame. frame_start coincides with (0,0). wr_data drops the 4'hA nibble. line_done pulses 240 times per frame. locked=1 after frame 1 ends. err_overrun=0.
- Stream begins mid-frame right after reset (line 100 active) -> wr_en=0 until 512 blank cycles have elapsed. The first write is (0,0) of the next frame. No error.
- One 340-pixel line in row 5 -> columns 336..339 not written. err_overrun=1 and stays 1. locked=0 at that frame's end. Next clean frame -> locked=1 and err_overrun still 1.
- Frame with 241 lines -> line 241 produces no writes, err_overrun=1, locked=0 at frame end.
- Frame with 200 lines followed by a clean frame -> locked=0 after the 200-line frame, err_overrun=0, locked=1 after the clean frame.
- Assert reset asynchronously mid-line (col=150) -> all outputs 0 before the next MCKF edge. After release, no writes until vblank, then a normal frame from (0,0).
